// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C receive-only slave: FSM states and bit count.
package i2c_pkg;

  // Bits per I2C byte (address+R/W or data), excluding the ACK bit.
  localparam int unsigned I2C_BITS = 8;

  // Value of the 3-bit bit counter when the last bit of a byte is sampled.
  localparam logic [2:0] BIT_CNT_LAST = 3'(I2C_BITS - 1);

  // Receiver state machine.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by a one-flop edge detector for one raw
// I2C line. The flops reset to 1 because an idle I2C bus is pulled high.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the asynchronous line and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver. Acknowledges its own address with R/W = 0,
// then ACKs every data byte and presents it on data_o with a one-clk
// load_command strobe. Read requests and other addresses are ignored.
// START and STOP take priority over bit sampling in the same clk.
// dbg_state mirrors the FSM state register for observation.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] data_o,
  output logic       load_command,
  output logic       busy,
  output i2c_state_e dbg_state
);

  logic       w_scl;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_sda;
  logic       w_sda_rise;
  logic       w_sda_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_last_bit;
  logic       w_addr_match;
  logic [7:0] w_shift_next;

  i2c_state_e r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_load;
  logic       r_sda_oe;

  i2c_sync_edge u_scl_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (scl_i),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (sda_i),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start      = w_sda_fall & w_scl;
  assign w_stop       = w_sda_rise & w_scl;
  assign w_shift_next = {r_shift[6:0], w_sda};
  assign w_last_bit   = (r_bit_cnt == BIT_CNT_LAST);
  assign w_addr_match = (w_shift_next[7:1] == SLAVE_ADDR) && !w_shift_next[0];

  // Receiver FSM: byte assembly, ACK drive and data hand-off.
  // The ACK window is tracked by r_sda_oe itself: the first SCL fall in an
  // ACK state opens it, the second closes it and moves on to DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_load    <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_load <= 1'b0;
      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'h00;
      end else if (w_start) begin
        r_state   <= ST_ADDR;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'h00;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_state <= w_addr_match ? ST_ADDR_ACK : ST_IGNORE;
              end
            end
          end
          ST_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_state <= ST_DATA_ACK;
              end
            end
          end
          ST_ADDR_ACK, ST_DATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
                if (r_state == ST_DATA_ACK) begin
                  r_data <= r_shift;
                  r_load <= 1'b1;
                end
              end else begin
                r_sda_oe  <= 1'b0;
                r_state   <= ST_DATA;
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'h00;
              end
            end
          end
          default: begin
            // IDLE and IGNORE wait for START/STOP, handled above.
          end
        endcase
      end
    end
  end

  assign sda_oe       = r_sda_oe;
  assign data_o       = r_data;
  assign load_command = r_load;
  assign busy         = (r_state == ST_ADDR_ACK) || (r_state == ST_DATA) ||
                        (r_state == ST_DATA_ACK);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: an I2C master driver, a load monitor feeding a
// scoreboard, a table of directed transactions, randomized transactions
// with expectations from a transaction-level model, and hand-written
// sequences for repeated START and reset during an ACK bit.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  localparam logic [6:0] ADDR = 7'h48;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  typedef struct {
    int              nb;         // bytes in the transaction (incl. address)
    logic [2:0][7:0] b;          // b[0] = address byte
    int              last_bits;  // bits of the final byte sent (8 = full)
    logic            exp_ack;    // address ACKed (and therefore data ACKed)
    int              exp_loads;  // load_command pulses
    logic [7:0]      exp_data;   // data_o after STOP
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] data_o;
  logic       load_command;
  logic       busy;
  i2c_state_e dbg_state;

  int         n_pass = 0;
  int         n_total = 0;
  int         width_err = 0;
  logic       load_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_data = 8'h00;

  // Open-drain bus: master drives m_sda, slave can only pull low.
  assign sda_line = m_sda & ~sda_oe;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(ADDR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_i        (m_scl),
    .sda_i        (sda_line),
    .sda_oe       (sda_oe),
    .data_o       (data_o),
    .load_command (load_command),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- load monitor ----------------
  always @(negedge clk) begin
    if (load_command) got_q.push_back(data_o);
    if (load_command && load_prev) width_err++;
    load_prev = load_command;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic quarter();
    repeat (Q) @(posedge clk);
  endtask

  task automatic send_start();
    m_sda = 1'b1; quarter();
    m_scl = 1'b1; quarter();
    m_sda = 1'b0; quarter();
    m_scl = 1'b0; quarter();
  endtask

  task automatic send_stop();
    m_sda = 1'b0; quarter();
    m_scl = 1'b1; quarter();
    m_sda = 1'b1; quarter();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    quarter();
    m_scl = 1'b1; quarter(); quarter();
    m_scl = 1'b0; quarter();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) send_bit(b[k]);
  endtask

  // Master releases SDA; ack reports whether the slave pulls it low.
  task automatic read_ack(output logic ack);
    m_sda = 1'b1; quarter();
    m_scl = 1'b1; quarter();
    #1 ack = sda_oe;
    quarter();
    m_scl = 1'b0; quarter();
  endtask

  // ---------------- reference model ----------------
  // A write to ADDR is ACKed; every complete data byte after it is ACKed
  // and handed downstream, in order. Anything else produces nothing.
  task automatic model_txn(input vec_t v, output logic acked);
    acked = (v.nb > 1 || v.last_bits == 8) && (v.b[0] == {ADDR, 1'b0});
    exp_q.delete();
    if (acked)
      for (int i = 1; i < v.nb; i++)
        if (i < v.nb - 1 || v.last_bits == 8) exp_q.push_back(v.b[i]);
  endtask

  function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int bits, input logic ack,
                              input int loads, input logic [7:0] data);
    vec_t v;
    v.nb = nb; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.last_bits = bits;
    v.exp_ack = ack; v.exp_loads = loads; v.exp_data = data;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic ack;
    logic acked;
    int   bits;
    model_txn(v, acked);
    got_q.delete();
    send_start();
    for (int i = 0; i < v.nb; i++) begin
      bits = (i == v.nb - 1) ? v.last_bits : 8;
      for (int k = 7; k >= 8 - bits; k--) send_bit(v.b[i][k]);
      if (bits == 8) begin
        read_ack(ack);
        check($sformatf("%s ack byte%0d", tag, i), ack, v.exp_ack);
        if (i == 0) check($sformatf("%s busy after addr", tag), busy, v.exp_ack);
      end
    end
    send_stop();
    quarter(); quarter();
    check($sformatf("%s loads", tag), got_q.size(), v.exp_loads);
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
      check($sformatf("%s load%0d data", tag, j), got_q[j], exp_q[j]);
    check($sformatf("%s data_o", tag), data_o, v.exp_data);
    check($sformatf("%s busy idle", tag), busy, 1'b0);
    check($sformatf("%s sda_oe idle", tag), sda_oe, 1'b0);
    check($sformatf("%s state idle", tag), 32'(dbg_state), 32'(ST_IDLE));
    check($sformatf("%s load width", tag), width_err, 0);
    m_data = v.exp_data;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t tbl[5];
    vec_t v;
    logic ack;
    logic acked;
    int   sel;

    tbl[0] = mk(2, 8'h90, 8'hA5, 8'h00, 8, 1'b1, 1, 8'hA5);  // addressed write
    tbl[1] = mk(2, 8'h92, 8'h11, 8'h00, 8, 1'b0, 0, 8'hA5);  // other address
    tbl[2] = mk(3, 8'h91, 8'h55, 8'h66, 8, 1'b0, 0, 8'hA5);  // read request
    tbl[3] = mk(2, 8'h90, 8'h3C, 8'h00, 5, 1'b1, 0, 8'hA5);  // STOP mid-byte
    tbl[4] = mk(3, 8'h90, 8'h12, 8'h34, 8, 1'b1, 2, 8'h34);  // two data bytes

    // Reset state
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst sda_oe", sda_oe, 1'b0);
    check("rst data_o", data_o, 8'h00);
    check("rst load", load_command, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Directed table
    for (int t = 0; t < 5; t++) run_txn(tbl[t], $sformatf("tbl%0d", t));

    // Repeated START after 4 data bits discards the partial byte
    got_q.delete();
    send_start();
    send_byte(8'h90);
    read_ack(ack); check("rs ack addr1", ack, 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_start();
    check("rs state addr", 32'(dbg_state), 32'(ST_ADDR));
    send_byte(8'h90);
    read_ack(ack); check("rs ack addr2", ack, 1'b1);
    send_byte(8'h5A);
    read_ack(ack); check("rs ack data", ack, 1'b1);
    send_stop(); quarter();
    check("rs loads", got_q.size(), 1);
    if (got_q.size() > 0) check("rs load data", got_q[0], 8'h5A);
    check("rs data_o", data_o, 8'h5A);
    m_data = 8'h5A;

    // Reset pulsed during a data ACK bit
    send_start();
    send_byte(8'h90);
    read_ack(ack); check("ra ack addr", ack, 1'b1);
    send_byte(8'hC3);
    m_sda = 1'b1; quarter();
    m_scl = 1'b1; quarter();
    #1 check("ra oe before rst", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ra oe in rst", sda_oe, 1'b0);
    check("ra data_o in rst", data_o, 8'h00);
    check("ra busy in rst", busy, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    m_data = 8'h00;
    quarter();
    m_scl = 1'b0; quarter();
    // Address without a fresh START must not be acknowledged
    send_byte(8'h90);
    read_ack(ack); check("ra no start ack", ack, 1'b0);
    send_stop(); quarter();
    run_txn(mk(2, 8'h90, 8'h77, 8'h00, 8, 1'b1, 1, 8'h77), "ra post");

    // Randomized transactions against the model
    for (int r = 0; r < 8; r++) begin
      v.nb = $urandom_range(1, 3);
      sel  = $urandom_range(0, 3);
      v.b[0] = (sel < 2) ? 8'h90 : (sel == 2) ? 8'h91 : 8'($urandom_range(0, 255));
      v.b[1] = 8'($urandom_range(0, 255));
      v.b[2] = 8'($urandom_range(0, 255));
      v.last_bits = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 8;
      model_txn(v, acked);
      v.exp_ack   = acked;
      v.exp_loads = exp_q.size();
      v.exp_data  = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : m_data;
      run_txn(v, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
